mdc_commutator: RTL and testbench
=================================

# mdc_commutator

Radix-2 MDC (multi-path delay commutator) reorder stage placed between two butterfly stages of the 8–2048-point FFT pipeline. It takes two parallel complex streams, delays the lower input by D samples and swaps the paths every D samples with the existing 2x2 `switch` block. It then delays the upper switch output by D samples, so that the next butterfly receives the sample pairs it needs. Data advances only on accepted samples, so the stage tolerates gaps in the input stream.

## Interface
Parameters:
- `LOG2D`, default 3 — log2 of the commutator delay D = 2^LOG2D; legal range 0..10 (D = 1..1024).

Ports:
- `clk` input 1 — system clock, rising-edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — input sample pair valid; every asserted cycle is accepted, and there is no backpressure.
- `x0_re`, `x0_im` input 16 each, signed — upper input sample.
- `x1_re`, `x1_im` input 16 each, signed — lower input sample.
- `out_valid` output 1 — output sample pair valid.
- `y0_re`, `y0_im` output 16 each, signed — upper output sample.
- `y1_re`, `y1_im` output 16 each, signed — lower output sample.
- `frame_start` input 1 — present only with `MDC_FRAME_SYNC_EN`.

## Operation
- Sample index n counts accepted samples from reset. k = n mod 2D is held in a (LOG2D+1)-bit wrapping counter.
- sel(n) = 1 when k ≥ D, otherwise 0. sel drives an instantiated `switch` (0 = pass, 1 = swap).
- Lower delay line (D entries × 32 bits):
  - d1[n] = x1[n−D].
  - Switch inputs are (x0[n], d1[n]).
- Switch outputs:
  - s0[m] = sel(m) ? x1[m−D] : x0[m].
  - s1[m] = sel(m) ? x0[m] : x1[m−D].
- Upper output delay line (D entries × 32 bits): y0 at sample n = s0[n−D], and y1 at sample n = s1[n].
- Implementation: either circular buffers sharing one LOG2D-bit pointer, or shift registers. Both lines advance only when `in_valid`=1. When `in_valid`=0, all state, the counter and the outputs hold.
- Priming: a `primed` flag sets once D samples have been accepted, and stays set until reset.
- `out_valid` = registered (`in_valid` & primed-at-that-sample), i.e. it is asserted for samples n ≥ D.
- No arithmetic; data passes bit-exact, with no width change.
- Reset mid-stream: counter, pointer, `primed`, `out_valid` and outputs clear immediately. Delay-line contents need not be cleared, because they are masked by `primed`.

## Timing
- Outputs are registered: sample n appears one clk after the cycle in which it is accepted.
- Latency from x0[m] to its appearance on the outputs:
  - on y1: m (when sel(m)=1);
  - on y0: m+D (when sel(m)=0).
- Reset values: `out_valid`=0, all y outputs = 0, k=0, `primed`=0.
- Counter wrap: k goes from 2D−1 to 0 on the accepted sample. sel changes on the sample where k crosses D or wraps.
- LOG2D=0: D=1, and sel toggles on every accepted sample.
- Gaps: `out_valid` drops on the cycle after a non-accepted cycle. The y outputs hold their last value.

## Configuration
- `MDC_FRAME_SYNC_EN` defined:
  - Adds the `frame_start` input.
  - When `frame_start`=1 and `in_valid`=1, that sample is taken as n=0: k restarts at 0 (sel=0) and `primed` clears.
  - `out_valid` then stays low for D accepted samples.
  - `frame_start` without `in_valid` is ignored.
- Undefined: there is no `frame_start` port, and k runs free from reset.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → `out_valid`=0 and all y = 0 within the same cycle. After release, the first `out_valid` occurs on accepted sample n=D.
- Reorder, LOG2D=1 (D=2), continuous `in_valid`, x0_re=n, x1_re=100+n (im = −re) → valid y0_re/y1_re pairs are (0,2), (1,3), (100,102), (101,103), then the same pattern for the next block, with y_im = −y_re.
- Gaps, D=2: the same stream with `in_valid` deasserted on every 3rd cycle → identical valid output sequence; y holds and `out_valid`=0 during gaps.
- LOG2D=0 (D=1): x0_re=n, x1_re=100+n → valid pairs (0,1), (100,101), (2,3), (102,103).
- LOG2D=10: 4096 continuous samples → first `out_valid` at n=1024; output matches the formula reference model bit-exact, including at the k wrap.
- `MDC_FRAME_SYNC_EN`, D=2: `frame_start` pulsed at n=5 → `out_valid` low for the next 2 accepted samples, then pairs follow the reorder pattern restarted at the new n=0.

Source files
------------

// File: rtl/mdc_commutator.sv
// ---------------------------------------------------------------------------
// mdc_commutator
//
// Radix-2 multi-path delay commutator stage. It sits between two butterfly
// stages of the FFT pipeline. The lower input is delayed by D = 2^LOG2D
// samples. The upper input and the delayed lower input are then passed or
// swapped every D samples by a 2x2 switch. Finally the upper switch output
// is delayed by another D samples, so the next butterfly sees the pairs it
// needs.
//
// All state advances only on accepted samples (in_valid = 1). When in_valid
// is low, all state holds, including the outputs.
//
// Optional feature macro: MDC_FRAME_SYNC_EN
//   defined   : adds the frame_start input. An accepted sample that has
//               frame_start = 1 restarts the sample index at n = 0. The
//               swap phase restarts and priming clears.
//   undefined : there is no frame_start port, and the swap phase runs free
//               from reset.
//
// Parameters
//   LOG2D       log2 of the commutator delay D, legal range 0..10.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   frame_start frame restart strobe (MDC_FRAME_SYNC_EN builds only)
//   in_valid    input sample pair valid; there is no backpressure
//   x0_re/x0_im upper input sample, signed 16-bit
//   x1_re/x1_im lower input sample, signed 16-bit
//   out_valid   output sample pair valid, registered
//   y0_re/y0_im upper output sample, registered
//   y1_re/y1_im lower output sample, registered
// ---------------------------------------------------------------------------

// 2x2 crossbar: i_sel = 0 passes a->a and b->b, i_sel = 1 swaps them.
module switch #(
   parameter int W = 32
) (
   input  logic         i_sel,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_a,
   output logic [W-1:0] o_b
);

   always_comb begin
      o_a = i_b;
      o_b = i_a;
      if (!i_sel) begin
         o_a = i_a;
         o_b = i_b;
      end
   end

endmodule

module mdc_commutator #(
   parameter int LOG2D = 3
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef MDC_FRAME_SYNC_EN
   input  logic               frame_start,
`endif
   input  logic               in_valid,
   input  logic signed [15:0] x0_re,
   input  logic signed [15:0] x0_im,
   input  logic signed [15:0] x1_re,
   input  logic signed [15:0] x1_im,
   output logic               out_valid,
   output logic signed [15:0] y0_re,
   output logic signed [15:0] y0_im,
   output logic signed [15:0] y1_re,
   output logic signed [15:0] y1_im
);

   localparam int D  = 1 << LOG2D;
   // When D = 1, the pointer is kept 1 bit wide so the buffers still have an index.
   localparam int PW = (LOG2D == 0) ? 1 : LOG2D;
   // Value of k on the last unprimed sample, n = D-1.
   localparam logic [LOG2D:0] K_PRIME = (LOG2D+1)'(D - 1);

   // k = n mod 2D; its top bit is the swap select, because k >= D exactly
   // when that bit is set.
   logic [LOG2D:0] r_k;
   logic [PW-1:0]  r_ptr;
   logic           r_primed;
   logic           r_out_valid;
   logic [31:0]    r_y0;
   logic [31:0]    r_y1;

   // Circular buffers that share r_ptr. The pointer has period D, so the
   // read location always holds the word written D accepted samples ago.
   logic [31:0]    r_dl1 [D];
   logic [31:0]    r_dl0 [D];

   logic           w_restart;
   logic [LOG2D:0] w_k;
   logic           w_primed;
   logic           w_sel;
   logic [31:0]    w_x0;
   logic [31:0]    w_x1;
   logic [31:0]    w_d1;
   logic [31:0]    w_s0;
   logic [31:0]    w_s1;
   logic [31:0]    w_y0;

`ifdef MDC_FRAME_SYNC_EN
   assign w_restart = in_valid & frame_start;
`else
   assign w_restart = 1'b0;
`endif

   // A restart sample is itself n = 0. The pointer is not restarted,
   // because the delay lines measure absolute sample age and do not depend
   // on frame phase.
   assign w_k      = w_restart ? '0 : r_k;
   assign w_primed = r_primed & ~w_restart;
   assign w_sel    = w_k[LOG2D];

   assign w_x0 = {x0_re, x0_im};
   assign w_x1 = {x1_re, x1_im};
   assign w_d1 = r_dl1[r_ptr];
   assign w_y0 = r_dl0[r_ptr];

   switch #(
      .W (32)
   ) u_switch (
      .i_sel (w_sel),
      .i_a   (w_x0),
      .i_b   (w_d1),
      .o_a   (w_s0),
      .o_b   (w_s1)
   );

   // Delay-line storage has no reset. Stale contents never reach a valid
   // output, because out_valid is gated by primed.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_dl1[r_ptr] <= w_x1;
         r_dl0[r_ptr] <= w_s0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k         <= '0;
         r_ptr       <= '0;
         r_primed    <= 1'b0;
         r_out_valid <= 1'b0;
         r_y0        <= '0;
         r_y1        <= '0;
      end else begin
         r_out_valid <= in_valid & w_primed;
         if (in_valid) begin
            r_k      <= w_k + (LOG2D+1)'(1);
            r_ptr    <= (LOG2D == 0) ? '0 : r_ptr + PW'(1);
            r_primed <= w_primed | (w_k == K_PRIME);
            r_y0     <= w_y0;
            r_y1     <= w_s1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign y0_re     = r_y0[31:16];
   assign y0_im     = r_y0[15:0];
   assign y1_re     = r_y1[31:16];
   assign y1_im     = r_y1[15:0];

endmodule

// File: tb/tb_mdc_commutator.sv
module tb_mdc_commutator;

   localparam int NI = 3;
   localparam int HN = 8192;
`ifdef MDC_FRAME_SYNC_EN
   localparam bit FRAME_SYNC = 1'b1;
`else
   localparam bit FRAME_SYNC = 1'b0;
`endif

   // Instance i uses LOG2D = lg_of(i).
   function automatic int lg_of(input int i);
      case (i)
         0:       return 1;
         1:       return 0;
         default: return 10;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0;
`ifdef MDC_FRAME_SYNC_EN
   logic        frame_start = 1'b0;
`endif
   logic [NI-1:0] ov;
   logic [15:0]   y0r [NI];
   logic [15:0]   y0i [NI];
   logic [15:0]   y1r [NI];
   logic [15:0]   y1i [NI];

   always #5 clk = ~clk;

   mdc_commutator #(.LOG2D(1)) u_d2 (
      .clk(clk), .rst_n(rst_n),
`ifdef MDC_FRAME_SYNC_EN
      .frame_start(frame_start),
`endif
      .in_valid(in_valid), .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
      .out_valid(ov[0]), .y0_re(y0r[0]), .y0_im(y0i[0]), .y1_re(y1r[0]), .y1_im(y1i[0]));

   mdc_commutator #(.LOG2D(0)) u_d1 (
      .clk(clk), .rst_n(rst_n),
`ifdef MDC_FRAME_SYNC_EN
      .frame_start(frame_start),
`endif
      .in_valid(in_valid), .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
      .out_valid(ov[1]), .y0_re(y0r[1]), .y0_im(y0i[1]), .y1_re(y1r[1]), .y1_im(y1i[1]));

   mdc_commutator #(.LOG2D(10)) u_d1024 (
      .clk(clk), .rst_n(rst_n),
`ifdef MDC_FRAME_SYNC_EN
      .frame_start(frame_start),
`endif
      .in_valid(in_valid), .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
      .out_valid(ov[2]), .y0_re(y0r[2]), .y0_im(y0i[2]), .y1_re(y1r[2]), .y1_im(y1i[2]));

   int          vec = 0;
   int          miss = 0;
   int          acc;
   int          n_rel;
   logic [31:0] h_x0 [HN];
   logic [31:0] h_x1 [HN];
   logic [31:0] h_s0 [NI][HN];
   logic [63:0] sb   [NI][$];
   logic        exp_v   [NI];
   logic        hold_ok [NI];
   logic [63:0] last    [NI];

   function automatic logic [31:0] ramp0(input int n);
      return {16'(n), 16'(-n)};
   endfunction

   function automatic logic [31:0] ramp1(input int n);
      return {16'(100 + n), 16'(-(100 + n))};
   endfunction

   task automatic model_clear();
      acc   = 0;
      n_rel = 0;
      for (int i = 0; i < NI; i++) begin
         sb[i].delete();
         exp_v[i]   = 1'b0;
         hold_ok[i] = 1'b0;
         last[i]    = '0;
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      model_clear();
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Drives one cycle, then advances the formula model and queues the
   // expected output. It returns 1 time unit after the capturing edge.
   task automatic drive(input logic v, input logic fs, input logic [31:0] a0, input logic [31:0] a1);
      int          d;
      logic        sel;
      logic [31:0] dd, s0, s1;
      logic [63:0] e;
      in_valid          = v;
      {x0_re, x0_im}    = a0;
      {x1_re, x1_im}    = a1;
`ifdef MDC_FRAME_SYNC_EN
      frame_start = fs;
`endif
      for (int i = 0; i < NI; i++) exp_v[i] = 1'b0;
      if (v && acc < HN) begin
         if (fs && FRAME_SYNC) n_rel = 0;
         h_x0[acc] = a0;
         h_x1[acc] = a1;
         for (int i = 0; i < NI; i++) begin
            d   = 1 << lg_of(i);
            sel = ((n_rel >> lg_of(i)) & 1) != 0;
            dd  = (acc >= d) ? h_x1[acc - d] : 32'h0;
            s0  = sel ? dd : a0;
            s1  = sel ? a0 : dd;
            h_s0[i][acc] = s0;
            if (n_rel >= d) begin
               e = {h_s0[i][acc - d], s1};
               sb[i].push_back(e);
               exp_v[i]   = 1'b1;
               last[i]    = e;
               hold_ok[i] = 1'b1;
            end else begin
               hold_ok[i] = 1'b0;
            end
         end
         acc++;
         n_rel++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < NI; i++) begin
         vec++;
         if (ov[i] !== 1'b0 || {y0r[i], y0i[i], y1r[i], y1i[i]} !== 64'h0) begin
            miss++;
            $display("FAIL reset_state inst%0d: out_valid=%b y=%h, required 0 and 0", i, ov[i],
                     {y0r[i], y0i[i], y1r[i], y1i[i]});
         end
      end
      for (int n = 0; n < 5; n++) begin
         drive(1'b1, 1'b0, ramp0(n), ramp1(n));
         vec++;
         if (ov[0] !== (n >= 2) || ov[1] !== (n >= 1)) begin
            miss++;
            $display("FAIL reset_first_valid n=%0d: d2=%b d1=%b, required %b %b", n, ov[0], ov[1], n >= 2, n >= 1);
         end
      end
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         vec++;
         if (ov[i] !== 1'b0 || {y0r[i], y0i[i], y1r[i], y1i[i]} !== 64'h0) begin
            miss++;
            $display("FAIL reset_midstream inst%0d: out_valid=%b y=%h, required 0 and 0", i, ov[i],
                     {y0r[i], y0i[i], y1r[i], y1i[i]});
         end
      end
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         drive(1'b1, 1'b0, ramp0(n), ramp1(n));
         vec++;
         if (ov[0] !== (n >= 2) || ov[1] !== (n >= 1)) begin
            miss++;
            $display("FAIL reset_restart_valid n=%0d: d2=%b d1=%b, required %b %b", n, ov[0], ov[1], n >= 2, n >= 1);
         end
      end
   endtask

   task automatic test_reorder();
      int          t_d2 [8] = '{0, 2, 1, 3, 100, 102, 101, 103};
      int          t_d1 [8] = '{0, 1, 100, 101, 2, 3, 102, 103};
      int          cnt [2] = '{0, 0};
      logic [63:0] got, want;
      do_reset();
      for (int c = 0; c < 16; c++) begin
         drive(1'b1, 1'b0, ramp0(acc), ramp1(acc));
         for (int i = 0; i < NI; i++) begin
            got = {y0r[i], y0i[i], y1r[i], y1i[i]};
            vec++;
            if (ov[i] !== exp_v[i]) begin
               miss++;
               $display("FAIL reorder_valid inst%0d sample %0d: out_valid=%b, required %b", i, acc - 1, ov[i], exp_v[i]);
            end
            if (exp_v[i]) begin
               want = sb[i].pop_front();
               vec++;
               if (got !== want) begin
                  miss++;
                  $display("FAIL reorder_data inst%0d sample %0d: y=%h, required %h", i, acc - 1, got, want);
               end
               if (i < 2 && cnt[i] < 4) begin
                  vec++;
                  if (i == 0 ? (int'(y0r[0]) != t_d2[2*cnt[0]] || int'(y1r[0]) != t_d2[2*cnt[0]+1])
                             : (int'(y0r[1]) != t_d1[2*cnt[1]] || int'(y1r[1]) != t_d1[2*cnt[1]+1])) begin
                     miss++;
                     $display("FAIL reorder_pair inst%0d #%0d: (%0d,%0d), required (%0d,%0d)", i, cnt[i],
                              y0r[i], y1r[i], i == 0 ? t_d2[2*cnt[0]] : t_d1[2*cnt[1]],
                              i == 0 ? t_d2[2*cnt[0]+1] : t_d1[2*cnt[1]+1]);
                  end
                  cnt[i]++;
               end
            end
         end
      end
   endtask

   task automatic test_gaps();
      logic        v;
      logic [63:0] got, want;
      do_reset();
      for (int c = 0; c < 24; c++) begin
         v = (c % 3) != 2;
         drive(v, 1'b0, ramp0(acc), ramp1(acc));
         for (int i = 0; i < NI; i++) begin
            got = {y0r[i], y0i[i], y1r[i], y1i[i]};
            vec++;
            if (ov[i] !== exp_v[i]) begin
               miss++;
               $display("FAIL gaps_valid inst%0d cycle %0d: out_valid=%b, required %b", i, c, ov[i], exp_v[i]);
            end
            if (exp_v[i]) begin
               want = sb[i].pop_front();
               vec++;
               if (got !== want) begin
                  miss++;
                  $display("FAIL gaps_data inst%0d cycle %0d: y=%h, required %h", i, c, got, want);
               end
            end else if (!v && hold_ok[i]) begin
               vec++;
               if (got !== last[i]) begin
                  miss++;
                  $display("FAIL gaps_hold inst%0d cycle %0d: y=%h, required %h", i, c, got, last[i]);
               end
            end
         end
      end
   endtask

   task automatic test_large();
      logic [63:0] got, want;
      int          first_v;
      do_reset();
      first_v = -1;
      for (int c = 0; c < 4096; c++) begin
         drive(1'b1, 1'b0, $urandom, $urandom);
         if (first_v < 0 && ov[2] === 1'b1) first_v = c;
         for (int i = 0; i < NI; i++) begin
            got = {y0r[i], y0i[i], y1r[i], y1i[i]};
            vec++;
            if (ov[i] !== exp_v[i]) begin
               miss++;
               $display("FAIL large_valid inst%0d sample %0d: out_valid=%b, required %b", i, c, ov[i], exp_v[i]);
            end
            if (exp_v[i]) begin
               want = sb[i].pop_front();
               vec++;
               if (got !== want) begin
                  miss++;
                  $display("FAIL large_data inst%0d sample %0d: y=%h, required %h", i, c, got, want);
               end
            end
         end
      end
      vec++;
      if (first_v != 1024) begin
         miss++;
         $display("FAIL large_first_valid: first out_valid at n=%0d, required 1024", first_v);
      end
   endtask

`ifdef MDC_FRAME_SYNC_EN
   task automatic test_frame_sync();
      logic [63:0] got, want;
      do_reset();
      for (int c = 0; c < 16; c++) begin
         if (c == 9) drive(1'b0, 1'b1, ramp0(acc), ramp1(acc));
         else        drive(1'b1, c == 5, ramp0(acc), ramp1(acc));
         for (int i = 0; i < NI; i++) begin
            got = {y0r[i], y0i[i], y1r[i], y1i[i]};
            vec++;
            if (ov[i] !== exp_v[i]) begin
               miss++;
               $display("FAIL frame_valid inst%0d cycle %0d: out_valid=%b, required %b", i, c, ov[i], exp_v[i]);
            end
            if (exp_v[i]) begin
               want = sb[i].pop_front();
               vec++;
               if (got !== want) begin
                  miss++;
                  $display("FAIL frame_data inst%0d cycle %0d: y=%h, required %h", i, c, got, want);
               end
            end
         end
         if (c == 5 || c == 6) begin
            vec++;
            if (ov[0] !== 1'b0) begin
               miss++;
               $display("FAIL frame_mask cycle %0d: out_valid=%b, required 0", c, ov[0]);
            end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reorder();
      test_gaps();
      test_large();
`ifdef MDC_FRAME_SYNC_EN
      test_frame_sync();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
